// File: rtl/op_unit.sv
// -----------------------------------------------------------------------------
// op_unit
//
// Datapath half of a microprogrammed shift-and-add engine. Each clock edge it
// executes the microoperations selected by the controller strobes and reports
// the branch conditions x (B[0]) and y (C == 0) back to the controller.
//
// Parameters:
//   W     datapath width (>= 2); the iteration counter is $clog2(W+1) bits.
//
// Ports:
//   clk   in   clock, all state changes on the rising edge
//   res   in   asynchronous active-low reset
//   ld    in   operand load (B <= din, A <= 0, C <= W, CY <= 0); overrides strobes
//   din   in   operand value [W-1:0]
//   t1    in   {CY,A} <= A + B
//   t2    in   B <= B >> 1
//   t4    in   A <= 0               (wins over t1 for A)
//   t5    in   C <= C - 1 (wraps)
//   t6    in   C <= W               (wins over t5)
//   t7    in   Q <= {Q[W-2:0], CY}  (old CY)
//   t8    in   CY <= 0              (wins over t1 for CY)
//   t9    in   R <= A, done pulses on the following cycle
//   x     out  B[0]
//   y     out  C == 0
//   cy    out  carry flag
//   q     out  shift register Q [W-1:0]
//   r     out  result register R [W-1:0]
//   done  out  high for the cycle after each t9 edge
//
// Build option:
//   OP_UNIT_SAT_EN  when defined, t1 saturates A to all ones on overflow
//                   (CY still set); otherwise the add wraps modulo 2^W.
// -----------------------------------------------------------------------------
module op_unit #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         res,
  input  logic         ld,
  input  logic [W-1:0] din,
  input  logic         t1,
  input  logic         t2,
  input  logic         t4,
  input  logic         t5,
  input  logic         t6,
  input  logic         t7,
  input  logic         t8,
  input  logic         t9,
  output logic         x,
  output logic         y,
  output logic         cy,
  output logic [W-1:0] q,
  output logic [W-1:0] r,
  output logic         done
);

  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] C_INIT = CW'(W);

  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [CW-1:0] r_c;
  logic          r_cy;
  logic [W-1:0]  r_q;
  logic [W-1:0]  r_r;
  logic          r_done;

  logic [W-1:0]  w_a_next;
  logic [W-1:0]  w_b_next;
  logic [CW-1:0] w_c_next;
  logic          w_cy_next;
  logic [W-1:0]  w_q_next;
  logic [W-1:0]  w_r_next;
  logic          w_done_next;

  // Adder result for t1, one bit wider so the carry falls out naturally.
  logic [W:0]    w_sum;
  logic [W-1:0]  w_add_a;
  logic          w_add_cy;

  assign w_sum = {1'b0, r_a} + {1'b0, r_b};

`ifdef OP_UNIT_SAT_EN
  // Any carry out means the true sum exceeded 2^W-1: clamp A, keep CY set.
  assign w_add_a  = w_sum[W] ? {W{1'b1}} : w_sum[W-1:0];
  assign w_add_cy = w_sum[W];
`else
  assign w_add_a  = w_sum[W-1:0];
  assign w_add_cy = w_sum[W];
`endif

  always_comb begin
    w_a_next    = r_a;
    w_b_next    = r_b;
    w_c_next    = r_c;
    w_cy_next   = r_cy;
    w_q_next    = r_q;
    w_r_next    = r_r;
    w_done_next = 1'b0;

    if (ld) begin
      // Load masks every strobe in the same cycle, including t9.
      w_b_next  = din;
      w_a_next  = '0;
      w_c_next  = C_INIT;
      w_cy_next = 1'b0;
    end else begin
      // Later assignments carry the higher priority within a register.
      if (t1) begin
        w_a_next  = w_add_a;
        w_cy_next = w_add_cy;
      end
      if (t4) w_a_next = '0;
      if (t2) w_b_next = r_b >> 1;
      if (t5) w_c_next = r_c - CW'(1);
      if (t6) w_c_next = C_INIT;
      // t7 samples the pre-edge carry, so t7+t8 shifts the old CY in first.
      if (t7) w_q_next = {r_q[W-2:0], r_cy};
      if (t8) w_cy_next = 1'b0;
      if (t9) w_r_next = r_a;
      w_done_next = t9;
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_a    <= '0;
      r_b    <= '0;
      r_c    <= '0;
      r_cy   <= 1'b0;
      r_q    <= '0;
      r_r    <= '0;
      r_done <= 1'b0;
    end else begin
      r_a    <= w_a_next;
      r_b    <= w_b_next;
      r_c    <= w_c_next;
      r_cy   <= w_cy_next;
      r_q    <= w_q_next;
      r_r    <= w_r_next;
      r_done <= w_done_next;
    end
  end

  // Flags come straight from registers so the controller never sees a
  // combinational path from its own strobes.
  assign x    = r_b[0];
  assign y    = (r_c == '0);
  assign cy   = r_cy;
  assign q    = r_q;
  assign r    = r_r;
  assign done = r_done;

endmodule

// File: tb/tb_op_unit.sv
module tb_op_unit;

  localparam int W = 8;

  localparam logic [7:0] T1 = 8'h01;
  localparam logic [7:0] T2 = 8'h02;
  localparam logic [7:0] T4 = 8'h04;
  localparam logic [7:0] T5 = 8'h08;
  localparam logic [7:0] T6 = 8'h10;
  localparam logic [7:0] T7 = 8'h20;
  localparam logic [7:0] T8 = 8'h40;
  localparam logic [7:0] T9 = 8'h80;

`ifdef OP_UNIT_SAT_EN
  localparam logic [7:0] R_OVF_B = 8'hFF;  // 0xE0 + 0x20 clamps
  localparam logic [7:0] R_OVF_C = 8'hFF;  // 0xFF + 0xFF clamps
`else
  localparam logic [7:0] R_OVF_B = 8'h00;  // 0xE0 + 0x20 wraps to 0x00
  localparam logic [7:0] R_OVF_C = 8'hFE;  // 0xFF + 0xFF wraps to 0xFE
`endif

  logic         clk = 1'b0;
  logic         res = 1'b0;
  logic         ld  = 1'b0;
  logic [W-1:0] din = '0;
  logic         t1 = 1'b0, t2 = 1'b0, t4 = 1'b0, t5 = 1'b0;
  logic         t6 = 1'b0, t7 = 1'b0, t8 = 1'b0, t9 = 1'b0;
  logic         x, y, cy, done;
  logic [W-1:0] q, r;

  always #5 clk = ~clk;

  op_unit #(.W(W)) dut (
    .clk  (clk),
    .res  (res),
    .ld   (ld),
    .din  (din),
    .t1   (t1),
    .t2   (t2),
    .t4   (t4),
    .t5   (t5),
    .t6   (t6),
    .t7   (t7),
    .t8   (t8),
    .t9   (t9),
    .x    (x),
    .y    (y),
    .cy   (cy),
    .q    (q),
    .r    (r),
    .done (done)
  );

  typedef struct packed {
    logic       x;
    logic       y;
    logic       cy;
    logic [7:0] q;
    logic [7:0] r;
    logic       done;
  } exp_t;

  typedef struct {
    bit         rst;
    bit         ld;
    logic [7:0] din;
    logic [7:0] st;
    exp_t       e;
    string      nm;
  } vec_t;

  vec_t  tbl[$];
  exp_t  sb_q[$];
  string sbn_q[$];
  int    errors = 0;
  int    checks = 0;

  function automatic exp_t mk(logic ex, logic ey, logic ecy, logic [7:0] eq,
                              logic [7:0] er, logic ed);
    exp_t e;
    e.x = ex; e.y = ey; e.cy = ecy; e.q = eq; e.r = er; e.done = ed;
    return e;
  endfunction

  function automatic void add(bit rst_v, bit ld_v, logic [7:0] din_v,
                              logic [7:0] st_v, exp_t e, string nm);
    vec_t v;
    v.rst = rst_v; v.ld = ld_v; v.din = din_v; v.st = st_v; v.e = e; v.nm = nm;
    tbl.push_back(v);
  endfunction

  task automatic set_strobes(input logic [7:0] st);
    t1 = st[0]; t2 = st[1]; t4 = st[2]; t5 = st[3];
    t6 = st[4]; t7 = st[5]; t8 = st[6]; t9 = st[7];
  endtask

  task automatic expect_push(input exp_t e, input string nm);
    sb_q.push_back(e);
    sbn_q.push_back(nm);
  endtask

  task automatic compare_pop();
    exp_t  e;
    exp_t  got;
    string nm;
    e  = sb_q.pop_front();
    nm = sbn_q.pop_front();
    got.x = x; got.y = y; got.cy = cy; got.q = q; got.r = r; got.done = done;
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL %s: got x=%0b y=%0b cy=%0b q=%02h r=%02h done=%0b, want x=%0b y=%0b cy=%0b q=%02h r=%02h done=%0b",
               nm, got.x, got.y, got.cy, got.q, got.r, got.done,
               e.x, e.y, e.cy, e.q, e.r, e.done);
    end else begin
      $display("ok   %s: x=%0b y=%0b cy=%0b q=%02h r=%02h done=%0b",
               nm, got.x, got.y, got.cy, got.q, got.r, got.done);
    end
  endtask

  task automatic run_vec(input vec_t v);
    if (v.rst) begin
      @(negedge clk);
      ld = 1'b0; din = '0; set_strobes(8'h00);
      res = 1'b0;
      expect_push(v.e, {v.nm, "_async"});
      #1 compare_pop();
      @(posedge clk);
      expect_push(v.e, {v.nm, "_held"});
      #1 compare_pop();
      @(negedge clk);
      res = 1'b1;
    end else begin
      @(negedge clk);
      ld = v.ld; din = v.din; set_strobes(v.st);
      expect_push(v.e, v.nm);
      @(posedge clk);
      #1 compare_pop();
    end
  endtask

  task automatic step(input bit ld_v, input logic [7:0] din_v, input logic [7:0] st_v,
                      input exp_t e, input string nm);
    vec_t v;
    v.rst = 1'b0; v.ld = ld_v; v.din = din_v; v.st = st_v; v.e = e; v.nm = nm;
    run_vec(v);
  endtask

  task automatic reset_seq(input string nm);
    vec_t v;
    v.rst = 1'b1; v.ld = 1'b0; v.din = '0; v.st = '0;
    v.e = mk(0, 1, 0, 8'h00, 8'h00, 0); v.nm = nm;
    run_vec(v);
  endtask

  initial begin
    logic [7:0] mb;
    int         mc;
    logic [7:0] st;

    // Load and B shift / x flag
    add(1, 0, 8'h00, 8'h00, mk(0, 1, 0, 8'h00, 8'h00, 0), "rst_a");
    add(0, 1, 8'h0B, 8'h00, mk(1, 0, 0, 8'h00, 8'h00, 0), "ld_0B");
    add(0, 0, 8'h00, T2,    mk(1, 0, 0, 8'h00, 8'h00, 0), "shr_05");
    add(0, 0, 8'h00, T2,    mk(0, 0, 0, 8'h00, 8'h00, 0), "shr_02");
    add(0, 0, 8'h00, T2,    mk(1, 0, 0, 8'h00, 8'h00, 0), "shr_01");
    add(0, 0, 8'h00, T2,    mk(0, 0, 0, 8'h00, 8'h00, 0), "shr_00");

    // Add / carry: A reaches 0xE0 with B = 0x20, then overflows
    add(1, 0, 8'h00, 8'h00,   mk(0, 1, 0, 8'h00, 8'h00, 0), "rst_b");
    add(0, 1, 8'h80, 8'h00,   mk(0, 0, 0, 8'h00, 8'h00, 0), "ld_80");
    add(0, 0, 8'h00, T1 | T2, mk(0, 0, 0, 8'h00, 8'h00, 0), "add_shr_1");
    add(0, 0, 8'h00, T1 | T2, mk(0, 0, 0, 8'h00, 8'h00, 0), "add_shr_2");
    add(0, 0, 8'h00, T1,      mk(0, 0, 0, 8'h00, 8'h00, 0), "add_E0");
    add(0, 0, 8'h00, T1,      mk(0, 0, 1, 8'h00, 8'h00, 0), "add_ovf");
    add(0, 0, 8'h00, T9,      mk(0, 0, 1, 8'h00, R_OVF_B, 1), "t9_ovf");
    add(0, 0, 8'h00, T7 | T8, mk(0, 0, 0, 8'h01, R_OVF_B, 0), "t7t8_q01");
    add(0, 0, 8'h00, T7,      mk(0, 0, 0, 8'h02, R_OVF_B, 0), "t7_q02");

    // Priorities: t8 over t1, t4 over t1, t7+t8, back-to-back t9
    add(1, 0, 8'h00, 8'h00,   mk(0, 1, 0, 8'h00, 8'h00, 0), "rst_c");
    add(0, 1, 8'hFF, 8'h00,   mk(1, 0, 0, 8'h00, 8'h00, 0), "ld_FF");
    add(0, 0, 8'h00, T1,      mk(1, 0, 0, 8'h00, 8'h00, 0), "add_FF");
    add(0, 0, 8'h00, T1 | T8, mk(1, 0, 0, 8'h00, 8'h00, 0), "t8_over_t1");
    add(0, 0, 8'h00, T9,      mk(1, 0, 0, 8'h00, R_OVF_C, 1), "t9_c");
    add(0, 0, 8'h00, T1,      mk(1, 0, 1, 8'h00, R_OVF_C, 0), "add_cy1");
    add(0, 0, 8'h00, T7,      mk(1, 0, 1, 8'h01, R_OVF_C, 0), "t7_q01");
    add(0, 0, 8'h00, T7 | T8, mk(1, 0, 0, 8'h03, R_OVF_C, 0), "t7t8_q03");
    add(0, 0, 8'h00, T1 | T4, mk(1, 0, 1, 8'h03, R_OVF_C, 0), "t4_over_t1");
    add(0, 0, 8'h00, T9,      mk(1, 0, 1, 8'h03, 8'h00, 1), "t9_a0");
    add(0, 0, 8'h00, T9,      mk(1, 0, 1, 8'h03, 8'h00, 1), "t9_b2b");
    add(0, 0, 8'h00, 8'h00,   mk(1, 0, 1, 8'h03, 8'h00, 0), "idle");

    // Counter: count down, wrap, t6 over t5
    add(1, 0, 8'h00, 8'h00, mk(0, 1, 0, 8'h00, 8'h00, 0), "rst_d");
    add(0, 1, 8'h20, 8'h00, mk(0, 0, 0, 8'h00, 8'h00, 0), "ld_20");
    for (int i = 1; i <= 7; i++) add(0, 0, 8'h00, T5, mk(0, 0, 0, 8'h00, 8'h00, 0), "dec");
    add(0, 0, 8'h00, T5, mk(0, 1, 0, 8'h00, 8'h00, 0), "dec_to_0");
    add(0, 0, 8'h00, T5, mk(0, 0, 0, 8'h00, 8'h00, 0), "dec_wrap");
    for (int i = 1; i <= 14; i++) add(0, 0, 8'h00, T5, mk(0, 0, 0, 8'h00, 8'h00, 0), "dec_from_F");
    add(0, 0, 8'h00, T5,      mk(0, 1, 0, 8'h00, 8'h00, 0), "dec_F_to_0");
    add(0, 0, 8'h00, T5 | T6, mk(0, 0, 0, 8'h00, 8'h00, 0), "t6_over_t5");
    for (int i = 1; i <= 7; i++) add(0, 0, 8'h00, T5, mk(0, 0, 0, 8'h00, 8'h00, 0), "dec_reload");
    add(0, 0, 8'h00, T5, mk(0, 1, 0, 8'h00, 8'h00, 0), "reload_is_8");

    foreach (tbl[i]) run_vec(tbl[i]);

    // Mid-run asynchronous reset with A=0x5A, C=3, R=0x5A
    reset_seq("rst_e");
    step(1, 8'h5A, 8'h00, mk(0, 0, 0, 8'h00, 8'h00, 0), "ld_5A");
    step(0, 8'h00, T1,    mk(0, 0, 0, 8'h00, 8'h00, 0), "add_5A");
    step(0, 8'h00, T9,    mk(0, 0, 0, 8'h00, 8'h5A, 1), "t9_5A");
    for (int i = 1; i <= 5; i++) step(0, 8'h00, T5, mk(0, 0, 0, 8'h00, 8'h5A, 0), "dec_to_3");
    @(negedge clk);
    ld = 1'b1; din = 8'hFF; set_strobes(T1 | T5 | T7 | T9);
    #2 res = 1'b0;
    expect_push(mk(0, 1, 0, 8'h00, 8'h00, 0), "midrun_async_rst");
    #1 compare_pop();
    @(posedge clk);
    expect_push(mk(0, 1, 0, 8'h00, 8'h00, 0), "midrun_rst_held");
    #1 compare_pop();
    @(negedge clk);
    res = 1'b1; ld = 1'b0; din = '0; set_strobes(8'h00);
    expect_push(mk(0, 1, 0, 8'h00, 8'h00, 0), "post_rst_idle");
    @(posedge clk);
    #1 compare_pop();

    // Multiply loop: A accumulates B on B[0], B halves, C counts 8 iterations.
    // 0x0D + 0x03 + 0x01 = 0x11.
    reset_seq("rst_f");
    step(1, 8'h0D, 8'h00, mk(1, 0, 0, 8'h00, 8'h00, 0), "ld_13");
    mb = 8'h0D;
    mc = 8;
    for (int it = 0; it < 8; it++) begin
      st = T2 | T5 | (mb[0] ? T1 : 8'h00);
      mb = mb >> 1;
      mc = mc - 1;
      step(0, 8'h00, st, mk(mb[0], (mc == 0), 0, 8'h00, 8'h00, 0), "mul_iter");
    end
    step(0, 8'h00, T9,    mk(0, 1, 0, 8'h00, 8'h11, 1), "mul_t9");
    step(0, 8'h00, 8'h00, mk(0, 1, 0, 8'h00, 8'h11, 0), "mul_done_clr");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/op_unit.md
# op_unit

Operational (datapath) unit that sits on the far side of the control/condition interface of the team's microprogrammed controller automata. It executes one microoperation per asserted control strobe (`t1`,`t2`,`t4`..`t9`) on every clock edge and returns the condition flags `x` and `y` that the controller branches on. Together with a controller it forms a complete shift-and-add processing loop: operand load, iterated add/shift/count, result capture.

## Interface
Parameters:
- `W`, 8, datapath width (≥2); counter width is `$clog2(W+1)`.

Ports:
- `clk`  in  1  clock, all state updates on rising edge.
- `res`  in  1  reset, asynchronous, active-low.
- `ld`  in  1  operand load strobe.
- `din`  in  W  operand value captured by `ld`.
- `t1`,`t2`,`t4`,`t5`,`t6`,`t7`,`t8`,`t9`  in  1 each  microoperation strobes from the controller.
- `x`  out  1  condition flag: `B[0]`.
- `y`  out  1  condition flag: counter `C == 0`.
- `cy`  out  1  carry flag.
- `q`  out  W  shift register `Q`.
- `r`  out  W  result register `R`.
- `done`  out  1  one-cycle pulse, cycle after `t9`.

## Operation
- Registers: `A`(W), `B`(W), `C`(counter), `CY`(1), `Q`(W), `R`(W), `done`(1). All are registered; `x`, `y` are combinational from registers only (no strobe-to-flag path).
- `ld` has priority over every strobe, same edge: `B<=din`, `A<=0`, `C<=W`, `CY<=0`; `Q`, `R` unchanged; all strobes ignored that cycle.
- Strobes (all sampled values are pre-edge register contents):
  - `t1`: `{CY,A} <= A + B` (W+1-bit sum).
  - `t2`: `B <= B >> 1`, logical, MSB filled 0.
  - `t4`: `A <= 0`.
  - `t5`: `C <= C - 1`; at `C==0` wraps to all ones of counter width.
  - `t6`: `C <= W`.
  - `t7`: `Q <= {Q[W-2:0], CY}` using old `CY`.
  - `t8`: `CY <= 0`.
  - `t9`: `R <= A` (old `A`); `done <= 1` next edge, else `done <= 0`.
- Simultaneous strobes on the same register, fixed priority:
  - `A`: `t4` over `t1` (A cleared; `CY` from `t1` still written unless `t8`).
  - `C`: `t6` over `t5`.
  - `CY`: `t8` over `t1`; `t7` with `t8` shifts in old `CY` then clears.
  - Strobes on different registers all take effect in the same edge.
- No strobe asserted: all registers hold; `done` returns 0.

## Timing
- Reset (`res`=0, asynchronous): `A=B=Q=R=0`, `C=0`, `CY=0`, `done=0`; thus `x=0`, `y=1`, `cy=0`, `q=0`, `r=0`. Release is synchronous to next `clk` edge; the first edge after release already executes strobes.
- Reset mid-operation: aborts immediately, no partial update survives.
- Latency: every microoperation visible on outputs 1 cycle after strobe edge; `x`/`y` reflect it the same cycle, available to the controller for its next-state decision on the following edge.
- `done`: high exactly one cycle, the cycle after the `t9` edge; back-to-back `t9` keeps `done` high continuously.

## Configuration
- `OP_UNIT_SAT_EN` defined: `t1` saturates — if W+1-bit sum exceeds 2^W−1, `A <= {W{1'b1}}` and `CY <= 1`; otherwise identical to wrapping add.
- Not defined: `t1` wraps modulo 2^W, `CY` = bit W of sum. Default build is without the macro.

## Test plan
- Reset: drive `res`=0 mid-run with `A=0x5A`, `C=3` -> all registers 0 asynchronously, `x=0`, `y=1`, `done=0`, outputs stable while reset held.
- Load/flags (W=8): `ld=1`, `din=0x0B` -> next cycle `B=0x0B`, `x=1`, `C=8`, `y=0`; `t2` -> `B=0x05`; `t2` twice more -> `B=0x01`, `x=1`; once more -> `x=0`.
- Add/carry: `A=0xF0`, `B=0x20`, `t1` -> `A=0x10`, `cy=1`; with `OP_UNIT_SAT_EN` -> `A=0xFF`, `cy=1`; `t1`+`t8` same edge -> `cy=0`.
- Counter: after `ld`, 8×`t5` -> `y=1` on the 8th; 9th `t5` -> `C=all ones`, `y=0`; `t5`+`t6` same edge -> `C=8`.
- Priority/shift: `t1`+`t4` with `A=0x30`,`B=0x01` -> `A=0`; `CY=1`, `Q=0x01`, `t7`+`t8` -> `Q=0x03`, `cy=0`.
- Full multiply loop driven as controller sequence (din=13 then A accumulates shifted B over 8 iterations) -> `t9` captures expected `R`, `done` high exactly one cycle after `t9`.
